// File: rtl/xbar_l2_pkg.sv
// -----------------------------------------------------------------------------
// xbar_l2_pkg
//
// Purpose:
//   Shared constants and types for the one-master / two-slave L2 crossbar.
//   Holds the default bus widths, the one-hot ID that master 0 stamps on
//   every request, and the rule that picks the slave-select address bit.
//
// Contents:
//   XBAR_*                 default widths and port counts
//   MASTER0_ID_BIT         bit position of master 0 in a one-hot ID
//   MASTER0_ID             one-hot ID value of master 0 (== 1)
//   slave_sel_bit()        address bit that chooses slave 0 / slave 1
//   XBAR_SLAVE_SEL_BIT     that bit for the default memory width
//   slave_sel_e            decoded slave selection
//
// Configuration macro: none in this file (see XBAR_L2_RESP_REG_EN in the
// response mux).
// -----------------------------------------------------------------------------
package xbar_l2_pkg;

  // Default port counts and widths used as parameter defaults by the top.
  localparam int XBAR_N_MASTER       = 1;
  localparam int XBAR_N_SLAVE        = 2;
  localparam int XBAR_ID_WIDTH       = 1;
  localparam int XBAR_ADDR_WIDTH     = 32;
  localparam int XBAR_DATA_WIDTH     = 32;
  localparam int XBAR_ADDR_MEM_WIDTH = 12;

  // Master 0 owns bit 0 of the one-hot ID; responses are claimed by
  // checking that bit only.
  localparam int MASTER0_ID_BIT = 0;
  localparam int MASTER0_ID     = 1 << MASTER0_ID_BIT;

  // Each slave holds 2**addr_mem_width words, so the first address bit
  // above the word address decides which slave is targeted.
  function automatic int slave_sel_bit(input int addr_mem_width);
    return addr_mem_width;
  endfunction

  localparam int XBAR_SLAVE_SEL_BIT = slave_sel_bit(XBAR_ADDR_MEM_WIDTH);

  // Decoded value of the slave-select bit.
  typedef enum logic {
    SLAVE_0 = 1'b0,
    SLAVE_1 = 1'b1
  } slave_sel_e;

endpackage : xbar_l2_pkg

// File: rtl/xbar_l2_resp_mux.sv
// -----------------------------------------------------------------------------
// xbar_l2_resp_mux
//
// Purpose:
//   Collects the two slave response channels and returns at most one of them
//   to master 0. A response is claimed only when its ID carries master 0's
//   bit. Slave 0 has fixed priority; a simultaneous slave 1 response is
//   dropped. With no claimed response the data bus reads as zero.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid_s, i_rdata_s,
//   i_id_s (s = 0,1)        slave response channels
//   o_valid, o_rdata        response towards master 0
//
// Configuration macro:
//   XBAR_L2_RESP_REG_EN  defined   -> outputs registered (1 cycle latency)
//                        undefined -> outputs combinational (0 latency)
//   In both builds a response present while reset is asserted is discarded.
// -----------------------------------------------------------------------------
module xbar_l2_resp_mux
  import xbar_l2_pkg::*;
#(
  parameter int DATA_WIDTH = XBAR_DATA_WIDTH,
  parameter int ID_WIDTH   = XBAR_ID_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_valid_0,
  input  logic [DATA_WIDTH-1:0] i_rdata_0,
  input  logic [ID_WIDTH-1:0]   i_id_0,

  input  logic                  i_valid_1,
  input  logic [DATA_WIDTH-1:0] i_rdata_1,
  input  logic [ID_WIDTH-1:0]   i_id_1,

  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic                  w_hit_0;
  logic                  w_hit_1;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_rdata;

  // A slave response belongs to master 0 only if it is valid and the
  // returned ID has master 0's one-hot bit set.
  assign w_hit_0 = i_valid_0 && i_id_0[MASTER0_ID_BIT];
  assign w_hit_1 = i_valid_1 && i_id_1[MASTER0_ID_BIT];

  // Fixed-priority selection: slave 0 first, slave 1 only when slave 0 is
  // silent. The data bus is forced to zero when nothing is claimed so the
  // master never sees stale slave data.
  always_comb begin
    w_valid = 1'b0;
    w_rdata = '0;
    if (w_hit_0) begin
      w_valid = 1'b1;
      w_rdata = i_rdata_0;
    end else if (w_hit_1) begin
      w_valid = 1'b1;
      w_rdata = i_rdata_1;
    end
  end

`ifdef XBAR_L2_RESP_REG_EN

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Registered response: one cycle of latency. Reset clears the register
  // and also swallows any response sampled on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= w_valid;
      r_rdata <= w_rdata;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;

  // Only bit MASTER0_ID_BIT of each ID takes part in the decision.
  logic w_unused_id;
  assign w_unused_id = ^{i_id_0, i_id_1};

`else

  // Combinational response: zero latency. While reset is held the response
  // is masked so nothing reaches the master during reset.
  assign o_valid = w_valid && !i_rst;
  assign o_rdata = i_rst ? '0 : w_rdata;

  // The clock has no job in the combinational build; only bit
  // MASTER0_ID_BIT of each ID takes part in the decision.
  logic w_unused_clk_id;
  assign w_unused_clk_id = ^{i_clk, i_id_0, i_id_1};

`endif

endmodule : xbar_l2_resp_mux

// File: rtl/one_master_two_slave_xbar_l2_wrap_v.sv
// -----------------------------------------------------------------------------
// one_master_two_slave_xbar_l2_wrap_v
//
// Purpose:
//   Connects a single master to two word-addressed L2 slaves. Address bit
//   ADDR_MEM_WIDTH selects the slave; the low ADDR_MEM_WIDTH bits are the
//   slave word address (no byte shift). Higher address bits are ignored.
//   The request path is purely combinational: slaves are always ready, so the
//   grant mirrors the request in the same cycle. Responses are arbitrated in
//   xbar_l2_resp_mux.
//
// Ports:
//   clk                     rising-edge clock
//   rst_n                   synchronous reset, ACTIVE-HIGH despite its name
//   data_*_M_i_0            master request (req, add, wen 1=store, wdata, be)
//   data_gnt_M_o_0          grant, equal to the request
//   data_r_valid_M_o_0,
//   data_r_rdata_M_o_0      response to master
//   data_*_S_o_s (s=0,1)    slave request (req, add, wen, wdata, be, ID)
//   data_r_*_S_i_s (s=0,1)  slave response (valid, rdata, ID)
//
// Configuration macro:
//   XBAR_L2_RESP_REG_EN  registers the response path (1 cycle latency);
//                        default build is combinational (0 latency).
// -----------------------------------------------------------------------------
module one_master_two_slave_xbar_l2_wrap_v
  import xbar_l2_pkg::*;
#(
  parameter int N_MASTER       = XBAR_N_MASTER,
  parameter int N_SLAVE        = XBAR_N_SLAVE,
  parameter int ID_WIDTH       = XBAR_ID_WIDTH,
  parameter int ADDR_WIDTH     = XBAR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = XBAR_DATA_WIDTH,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int ADDR_MEM_WIDTH = XBAR_ADDR_MEM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // Master 0 request
  input  logic                      data_req_M_i_0,
  input  logic [ADDR_WIDTH-1:0]     data_add_M_i_0,
  input  logic                      data_wen_M_i_0,
  input  logic [DATA_WIDTH-1:0]     data_wdata_M_i_0,
  input  logic [BE_WIDTH-1:0]       data_be_M_i_0,

  // Master 0 grant / response
  output logic                      data_gnt_M_o_0,
  output logic                      data_r_valid_M_o_0,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_M_o_0,

  // Slave 0 request
  output logic                      data_req_S_o_0,
  output logic [ADDR_MEM_WIDTH-1:0] data_add_S_o_0,
  output logic                      data_wen_S_o_0,
  output logic [DATA_WIDTH-1:0]     data_wdata_S_o_0,
  output logic [BE_WIDTH-1:0]       data_be_S_o_0,
  output logic [ID_WIDTH-1:0]       data_ID_S_o_0,

  // Slave 1 request
  output logic                      data_req_S_o_1,
  output logic [ADDR_MEM_WIDTH-1:0] data_add_S_o_1,
  output logic                      data_wen_S_o_1,
  output logic [DATA_WIDTH-1:0]     data_wdata_S_o_1,
  output logic [BE_WIDTH-1:0]       data_be_S_o_1,
  output logic [ID_WIDTH-1:0]       data_ID_S_o_1,

  // Slave 0 response
  input  logic                      data_r_valid_S_i_0,
  input  logic [DATA_WIDTH-1:0]     data_r_rdata_S_i_0,
  input  logic [ID_WIDTH-1:0]       data_r_ID_S_i_0,

  // Slave 1 response
  input  logic                      data_r_valid_S_i_1,
  input  logic [DATA_WIDTH-1:0]     data_r_rdata_S_i_1,
  input  logic [ID_WIDTH-1:0]       data_r_ID_S_i_1
);

  localparam int                  LP_SEL_BIT = slave_sel_bit(ADDR_MEM_WIDTH);
  localparam logic [ID_WIDTH-1:0] LP_M0_ID   = ID_WIDTH'(MASTER0_ID);

  slave_sel_e                w_sel;
  logic [ADDR_MEM_WIDTH-1:0] w_word_add;

  // Slave decode. Anything above the select bit is ignored on purpose, so
  // the two slaves alias throughout the rest of the address space.
  assign w_sel      = slave_sel_e'(data_add_M_i_0[LP_SEL_BIT]);
  assign w_word_add = data_add_M_i_0[ADDR_MEM_WIDTH-1:0];

  // Only req is steered; address, write data, byte enables and wen go to
  // both slaves and the non-selected one simply ignores them. Nothing here
  // depends on reset: the request side keeps following the master.
  assign data_req_S_o_0   = data_req_M_i_0 && (w_sel == SLAVE_0);
  assign data_add_S_o_0   = w_word_add;
  assign data_wen_S_o_0   = data_wen_M_i_0;
  assign data_wdata_S_o_0 = data_wdata_M_i_0;
  assign data_be_S_o_0    = data_be_M_i_0;
  assign data_ID_S_o_0    = LP_M0_ID;

  assign data_req_S_o_1   = data_req_M_i_0 && (w_sel == SLAVE_1);
  assign data_add_S_o_1   = w_word_add;
  assign data_wen_S_o_1   = data_wen_M_i_0;
  assign data_wdata_S_o_1 = data_wdata_M_i_0;
  assign data_be_S_o_1    = data_be_M_i_0;
  assign data_ID_S_o_1    = LP_M0_ID;

  // Slaves never stall, so every request is granted immediately.
  assign data_gnt_M_o_0 = data_req_M_i_0;

  // Response arbitration (slave 0 priority, ID filtering, optional register).
  xbar_l2_resp_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_resp_mux (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_valid_0 (data_r_valid_S_i_0),
    .i_rdata_0 (data_r_rdata_S_i_0),
    .i_id_0    (data_r_ID_S_i_0),
    .i_valid_1 (data_r_valid_S_i_1),
    .i_rdata_1 (data_r_rdata_S_i_1),
    .i_id_1    (data_r_ID_S_i_1),
    .o_valid   (data_r_valid_M_o_0),
    .o_rdata   (data_r_rdata_M_o_0)
  );

  // The port counts are fixed at one master and two slaves; the address
  // bits above the select bit are deliberately don't-care.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{(N_MASTER == 1), (N_SLAVE == 2),
                          data_add_M_i_0[ADDR_WIDTH-1:LP_SEL_BIT+1]};

endmodule : one_master_two_slave_xbar_l2_wrap_v

// File: tb/tb_one_master_two_slave_xbar_l2_wrap_v.sv
// -----------------------------------------------------------------------------
// tb_one_master_two_slave_xbar_l2_wrap_v
//
// Self-checking bench for the one-master / two-slave L2 crossbar. Directed
// scenarios cover reset, store and load routing, slave 1 selection, dual
// response priority and ID filtering; a randomized loop checks every output
// against a behavioural model of the routing and response rules.
// Honours XBAR_L2_RESP_REG_EN for the response latency.
// -----------------------------------------------------------------------------
module tb_one_master_two_slave_xbar_l2_wrap_v;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int MW  = 12;
  localparam int IW  = 1;

  logic          clk;
  logic          rst_n;
  logic          data_req_M_i_0;
  logic [AW-1:0] data_add_M_i_0;
  logic          data_wen_M_i_0;
  logic [DW-1:0] data_wdata_M_i_0;
  logic [BW-1:0] data_be_M_i_0;
  logic          data_gnt_M_o_0;
  logic          data_r_valid_M_o_0;
  logic [DW-1:0] data_r_rdata_M_o_0;
  logic          data_req_S_o_0,   data_req_S_o_1;
  logic [MW-1:0] data_add_S_o_0,   data_add_S_o_1;
  logic          data_wen_S_o_0,   data_wen_S_o_1;
  logic [DW-1:0] data_wdata_S_o_0, data_wdata_S_o_1;
  logic [BW-1:0] data_be_S_o_0,    data_be_S_o_1;
  logic [IW-1:0] data_ID_S_o_0,    data_ID_S_o_1;
  logic          data_r_valid_S_i_0, data_r_valid_S_i_1;
  logic [DW-1:0] data_r_rdata_S_i_0, data_r_rdata_S_i_1;
  logic [IW-1:0] data_r_ID_S_i_0,    data_r_ID_S_i_1;

  int passCount  = 0;
  int checkCount = 0;

  one_master_two_slave_xbar_l2_wrap_v dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_req_M_i_0     (data_req_M_i_0),
    .data_add_M_i_0     (data_add_M_i_0),
    .data_wen_M_i_0     (data_wen_M_i_0),
    .data_wdata_M_i_0   (data_wdata_M_i_0),
    .data_be_M_i_0      (data_be_M_i_0),
    .data_gnt_M_o_0     (data_gnt_M_o_0),
    .data_r_valid_M_o_0 (data_r_valid_M_o_0),
    .data_r_rdata_M_o_0 (data_r_rdata_M_o_0),
    .data_req_S_o_0     (data_req_S_o_0),
    .data_add_S_o_0     (data_add_S_o_0),
    .data_wen_S_o_0     (data_wen_S_o_0),
    .data_wdata_S_o_0   (data_wdata_S_o_0),
    .data_be_S_o_0      (data_be_S_o_0),
    .data_ID_S_o_0      (data_ID_S_o_0),
    .data_req_S_o_1     (data_req_S_o_1),
    .data_add_S_o_1     (data_add_S_o_1),
    .data_wen_S_o_1     (data_wen_S_o_1),
    .data_wdata_S_o_1   (data_wdata_S_o_1),
    .data_be_S_o_1      (data_be_S_o_1),
    .data_ID_S_o_1      (data_ID_S_o_1),
    .data_r_valid_S_i_0 (data_r_valid_S_i_0),
    .data_r_rdata_S_i_0 (data_r_rdata_S_i_0),
    .data_r_ID_S_i_0    (data_r_ID_S_i_0),
    .data_r_valid_S_i_1 (data_r_valid_S_i_1),
    .data_r_rdata_S_i_1 (data_r_rdata_S_i_1),
    .data_r_ID_S_i_1    (data_r_ID_S_i_1)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait until the outputs reflect the inputs just driven: a short delay for
  // the combinational build, the next rising edge plus a margin when the
  // response is registered.
  task automatic settle();
`ifdef XBAR_L2_RESP_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // Drive all master and slave inputs in one go.
  task automatic applyStimulus(input logic req, input logic [AW-1:0] add,
                               input logic wen, input logic [DW-1:0] wdata,
                               input logic [BW-1:0] be,
                               input logic v0, input logic [DW-1:0] d0, input logic [IW-1:0] id0,
                               input logic v1, input logic [DW-1:0] d1, input logic [IW-1:0] id1);
    data_req_M_i_0     = req;
    data_add_M_i_0     = add;
    data_wen_M_i_0     = wen;
    data_wdata_M_i_0   = wdata;
    data_be_M_i_0      = be;
    data_r_valid_S_i_0 = v0;
    data_r_rdata_S_i_0 = d0;
    data_r_ID_S_i_0    = id0;
    data_r_valid_S_i_1 = v1;
    data_r_rdata_S_i_1 = d1;
    data_r_ID_S_i_1    = id1;
  endtask

  // Reset held while a slave returns a response: the response is dropped,
  // yet the request side still follows the master.
  task automatic test_reset();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_10FE, 1'b0, 32'h0, 4'h0,
                  1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkCount++;
    if (data_r_valid_M_o_0 !== 1'b0)
      $display("[TB] FAIL reset_valid actual=%b required=0", data_r_valid_M_o_0);
    else passCount++;
    checkCount++;
    if (data_r_rdata_M_o_0 !== 32'h0)
      $display("[TB] FAIL reset_rdata actual=%h required=00000000", data_r_rdata_M_o_0);
    else passCount++;
    checkCount++;
    if (data_req_S_o_1 !== 1'b1)
      $display("[TB] FAIL reset_req_s1 actual=%b required=1", data_req_S_o_1);
    else passCount++;
    checkCount++;
    if (data_gnt_M_o_0 !== 1'b1)
      $display("[TB] FAIL reset_gnt actual=%b required=1", data_gnt_M_o_0);
    else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Store to slave 0: all request fields routed, grant in the same cycle.
  task automatic test_store();
    applyStimulus(1'b1, 32'h0000_00FE, 1'b1, 32'hDEA0_BEE0, 4'hF,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkCount++;
    if ({data_req_S_o_0, data_req_S_o_1, data_gnt_M_o_0} !== 3'b101)
      $display("[TB] FAIL store_req_gnt actual=%b required=101",
               {data_req_S_o_0, data_req_S_o_1, data_gnt_M_o_0});
    else passCount++;
    checkCount++;
    if (data_add_S_o_0 !== 12'h0FE)
      $display("[TB] FAIL store_add actual=%h required=0fe", data_add_S_o_0);
    else passCount++;
    checkCount++;
    if ({data_wen_S_o_0, data_be_S_o_0, data_ID_S_o_0} !== 6'b1_1111_1)
      $display("[TB] FAIL store_wen_be_id actual=%b required=111111",
               {data_wen_S_o_0, data_be_S_o_0, data_ID_S_o_0});
    else passCount++;
    checkCount++;
    if (data_wdata_S_o_0 !== 32'hDEA0_BEE0)
      $display("[TB] FAIL store_wdata actual=%h required=dea0bee0", data_wdata_S_o_0);
    else passCount++;
  endtask

  // Load from slave 0 with a matching response.
  task automatic test_load();
    applyStimulus(1'b1, 32'h0000_00FE, 1'b0, 32'h0, 4'hF,
                  1'b1, 32'hDEA0_BEE0, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    checkCount++;
    if (data_r_valid_M_o_0 !== 1'b1)
      $display("[TB] FAIL load_valid actual=%b required=1", data_r_valid_M_o_0);
    else passCount++;
    checkCount++;
    if (data_r_rdata_M_o_0 !== 32'hDEA0_BEE0)
      $display("[TB] FAIL load_rdata actual=%h required=dea0bee0", data_r_rdata_M_o_0);
    else passCount++;
  endtask

  // Address bit 12 set: request goes to slave 1 only.
  task automatic test_slave1();
    applyStimulus(1'b1, 32'h0000_10FE, 1'b0, 32'h0, 4'h3,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkCount++;
    if ({data_req_S_o_0, data_req_S_o_1} !== 2'b01)
      $display("[TB] FAIL slave1_req actual=%b required=01", {data_req_S_o_0, data_req_S_o_1});
    else passCount++;
    checkCount++;
    if (data_add_S_o_1 !== 12'h0FE)
      $display("[TB] FAIL slave1_add actual=%h required=0fe", data_add_S_o_1);
    else passCount++;
  endtask

  // Both slaves respond: slave 0 wins, valid for just that one cycle.
  task automatic test_dual();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                  1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h2222_2222, 1'b1);
    settle();
    checkCount++;
    if (data_r_valid_M_o_0 !== 1'b1 || data_r_rdata_M_o_0 !== 32'h1111_1111)
      $display("[TB] FAIL dual_resp actual=%b/%h required=1/11111111",
               data_r_valid_M_o_0, data_r_rdata_M_o_0);
    else passCount++;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    checkCount++;
    if (data_r_valid_M_o_0 !== 1'b0)
      $display("[TB] FAIL dual_one_cycle actual=%b required=0", data_r_valid_M_o_0);
    else passCount++;
  endtask

  // Idle master and responses carrying someone else's ID.
  task automatic test_idle_mismatch();
    applyStimulus(1'b0, 32'h0000_10FE, 1'b1, 32'h1234_5678, 4'hF,
                  1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    settle();
    checkCount++;
    if ({data_req_S_o_0, data_req_S_o_1, data_gnt_M_o_0} !== 3'b000)
      $display("[TB] FAIL idle_req_gnt actual=%b required=000",
               {data_req_S_o_0, data_req_S_o_1, data_gnt_M_o_0});
    else passCount++;
    checkCount++;
    if (data_r_valid_M_o_0 !== 1'b0 || data_r_rdata_M_o_0 !== 32'h0)
      $display("[TB] FAIL id_mismatch actual=%b/%h required=0/00000000",
               data_r_valid_M_o_0, data_r_rdata_M_o_0);
    else passCount++;
  endtask

  // Random traffic checked against the routing/response rules written as
  // plain arithmetic over arrays of slave responses.
  task automatic test_random();
    logic          req, wen;
    logic [AW-1:0] add;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          rv  [2];
    logic [DW-1:0] rd  [2];
    logic [IW-1:0] rid [2];
    int            target;
    logic          expValid;
    logic [DW-1:0] expData;
    for (int it = 0; it < 60; it++) begin
      req   = 1'($urandom);
      wen   = 1'($urandom);
      add   = $urandom;
      wdata = $urandom;
      be    = 4'($urandom);
      for (int s = 0; s < 2; s++) begin
        rv[s]  = 1'($urandom);
        rd[s]  = $urandom;
        rid[s] = 1'($urandom);
      end
      applyStimulus(req, add, wen, wdata, be,
                    rv[0], rd[0], rid[0], rv[1], rd[1], rid[1]);
      settle();
      target   = (add / (1 << MW)) % 2;
      expValid = 1'b0;
      expData  = '0;
      for (int s = 0; s < 2; s++) begin
        if (!expValid && rv[s] && rid[s] == 1'b1) begin
          expValid = 1'b1;
          expData  = rd[s];
        end
      end
      checkCount++;
      if (data_req_S_o_0 !== (req && target == 0) || data_req_S_o_1 !== (req && target == 1)
          || data_gnt_M_o_0 !== req)
        $display("[TB] FAIL rand_req it=%0d actual=%b%b%b required=%b%b%b", it,
                 data_req_S_o_0, data_req_S_o_1, data_gnt_M_o_0,
                 req && target == 0, req && target == 1, req);
      else passCount++;
      checkCount++;
      if (data_add_S_o_0 !== MW'(add % (1 << MW)) || data_add_S_o_1 !== MW'(add % (1 << MW)))
        $display("[TB] FAIL rand_add it=%0d actual=%h/%h required=%h", it,
                 data_add_S_o_0, data_add_S_o_1, add % (1 << MW));
      else passCount++;
      checkCount++;
      if ({data_wen_S_o_0, data_wdata_S_o_0, data_be_S_o_0, data_ID_S_o_0} !== {wen, wdata, be, 1'b1}
          || {data_wen_S_o_1, data_wdata_S_o_1, data_be_S_o_1, data_ID_S_o_1} !== {wen, wdata, be, 1'b1})
        $display("[TB] FAIL rand_fields it=%0d actual=%b/%h/%h required=%b/%h/%h", it,
                 data_wen_S_o_1, data_wdata_S_o_1, data_be_S_o_1, wen, wdata, be);
      else passCount++;
      checkCount++;
      if (data_r_valid_M_o_0 !== expValid || data_r_rdata_M_o_0 !== expData)
        $display("[TB] FAIL rand_resp it=%0d actual=%b/%h required=%b/%h", it,
                 data_r_valid_M_o_0, data_r_rdata_M_o_0, expValid, expData);
      else passCount++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store();
    test_load();
    test_slave1();
    test_dual();
    test_idle_mismatch();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_one_master_two_slave_xbar_l2_wrap_v
